vga_draw_scheduler: RTL

- Shares the single pixel-write port of the VGA adapter (x, y, colour, plot) between several drawing requesters, such as paddle, ball and block erase/draw engines.
- Each requester asks for a solid rectangle fill. The scheduler arbitrates round-robin, then rasterises the granted rectangle at one pixel per cycle.
- A priority full-screen clear replaces the ad-hoc black-screen sweep.
- Sits between game logic and the 160x120 vga_adapter.

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/rect_rasterizer.sv | 104 ++++++++++
 rtl/vga_draw_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen constants, widths, FSM states and rectangle job type
//
// Purpose: common definitions for the VGA draw scheduler and its rasteriser.
// Contents: SCREEN_W/SCREEN_H visible area, X_W/Y_W/COLOUR_W port widths,
//           state_t scheduler states, rect_t rectangle job (w/h held as pixel
//           counts, never zero), clear_rect() full-screen clear job.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAW   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // w and h are pixel counts; the widths hold a full-screen 160x120 clear.
  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [X_W-1:0]      w;
    logic [Y_W-1:0]      h;
    logic [COLOUR_W-1:0] colour;
  } rect_t;

  function automatic rect_t clear_rect();
    rect_t r;
    r.x      = '0;
    r.y      = '0;
    r.w      = X_W'(SCREEN_W);
    r.h      = Y_W'(SCREEN_H);
    r.colour = '0;
    return r;
  endfunction

endpackage

// File: rtl/rect_rasterizer.sv
// rtl/rect_rasterizer.sv - row-major solid rectangle rasteriser, one pixel per cycle
//
// Purpose: on i_start, captures i_rect and emits its pixels (x fastest), one per
//          cycle, clipping pixels outside the visible screen.
// Ports:
//   i_clock, i_reset       clock, asynchronous active-high reset
//   i_start                1-cycle pulse; first pixel appears on the next cycle
//   i_rect                 rectangle job (counts, not minus-one)
//   o_plot                 pixel write strobe (0 for clipped pixels)
//   o_plot_x/o_plot_y      pixel coordinates, held while o_plot=0
//   o_plot_colour          pixel colour, held while o_plot=0
//   o_last                 high alongside the final pixel slot of the job
module rect_rasterizer
  import vga_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  rect_t               i_rect,
  output logic                o_plot,
  output logic [X_W-1:0]      o_plot_x,
  output logic [Y_W-1:0]      o_plot_y,
  output logic [COLOUR_W-1:0] o_plot_colour,
  output logic                o_last
);

  rect_t               r_rect;
  logic [X_W-1:0]      r_col;
  logic [Y_W-1:0]      r_row;
  logic                r_active;
  logic                r_plot;
  logic                r_last;
  logic [X_W-1:0]      r_plot_x;
  logic [Y_W-1:0]      r_plot_y;
  logic [COLOUR_W-1:0] r_plot_colour;

  rect_t               w_src;
  logic [X_W-1:0]      w_col;
  logic [Y_W-1:0]      w_row;
  logic                w_emit;
  logic [X_W:0]        w_sum_x;
  logic [Y_W:0]        w_sum_y;
  logic                w_vis;
  logic                w_end_col;
  logic                w_end_row;
  logic                w_is_last;

  // On the start cycle the pixel source is the incoming job at (0,0), so the
  // first pixel is registered on the same edge that loads the job.
  always_comb begin
    w_src     = i_start ? i_rect : r_rect;
    w_col     = i_start ? '0 : r_col;
    w_row     = i_start ? '0 : r_row;
    w_emit    = i_start | r_active;
    // One bit wider than the ports so off-screen sums never wrap into view.
    w_sum_x   = {1'b0, w_src.x} + {1'b0, w_col};
    w_sum_y   = {1'b0, w_src.y} + {1'b0, w_row};
    w_vis     = (w_sum_x < (X_W+1)'(SCREEN_W)) && (w_sum_y < (Y_W+1)'(SCREEN_H));
    w_end_col = (w_col == X_W'(w_src.w - X_W'(1)));
    w_end_row = (w_row == Y_W'(w_src.h - Y_W'(1)));
    w_is_last = w_end_col && w_end_row;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rect        <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_active      <= 1'b0;
      r_plot        <= 1'b0;
      r_last        <= 1'b0;
      r_plot_x      <= '0;
      r_plot_y      <= '0;
      r_plot_colour <= '0;
    end else if (w_emit) begin
      r_rect   <= w_src;
      r_plot   <= w_vis;
      r_last   <= w_is_last;
      r_active <= !w_is_last;
      if (w_vis) begin
        r_plot_x      <= w_sum_x[X_W-1:0];
        r_plot_y      <= w_sum_y[Y_W-1:0];
        r_plot_colour <= w_src.colour;
      end
      if (w_end_col) begin
        r_col <= '0;
        r_row <= w_row + Y_W'(1);
      end else begin
        r_col <= w_col + X_W'(1);
        r_row <= w_row;
      end
    end else begin
      r_plot <= 1'b0;
      r_last <= 1'b0;
    end
  end

  assign o_plot        = r_plot;
  assign o_plot_x      = r_plot_x;
  assign o_plot_y      = r_plot_y;
  assign o_plot_colour = r_plot_colour;
  assign o_last        = r_last;

endmodule

// File: rtl/vga_draw_scheduler.sv
// rtl/vga_draw_scheduler.sv - round-robin rectangle fill scheduler for the VGA pixel port
//
// Purpose: arbitrates NUM_REQ rectangle-fill requesters (round-robin) plus a
//          priority full-screen clear onto the single VGA adapter write port.
// Ports:
//   i_clock, i_reset          clock, asynchronous active-high reset
//   i_req                     per-requester request level
//   i_req_x/_y/_w/_h/_colour  packed per-requester rectangle (w/h are size-1)
//   o_grant                   one-hot pulse, parameters captured this cycle
//   o_done                    one-hot pulse after the requester's last pixel
//   i_clear_req               full-screen clear to colour 0, highest priority
//   o_clear_done              pulse after the clear completes
//   o_busy                    high in every state except IDLE
//   o_plot_x/_y/_colour/o_plot  pixel stream to the adapter
module vga_draw_scheduler
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIM_W   = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ*X_W-1:0]      i_req_x,
  input  logic [NUM_REQ*Y_W-1:0]      i_req_y,
  input  logic [NUM_REQ*DIM_W-1:0]    i_req_w,
  input  logic [NUM_REQ*DIM_W-1:0]    i_req_h,
  input  logic [NUM_REQ*COLOUR_W-1:0] i_req_colour,
  output logic [NUM_REQ-1:0]          o_grant,
  output logic [NUM_REQ-1:0]          o_done,
  input  logic                        i_clear_req,
  output logic                        o_clear_done,
  output logic                        o_busy,
  output logic [X_W-1:0]              o_plot_x,
  output logic [Y_W-1:0]              o_plot_y,
  output logic [COLOUR_W-1:0]         o_plot_colour,
  output logic                        o_plot
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_rr_ptr;
  rect_t                r_job;
  logic                 r_job_clear;
  logic [IDX_W-1:0]     r_job_idx;
  logic                 r_clear_pend;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_clear_done;
  logic                 r_busy;

  logic                 w_clear;
  logic                 w_any;
  logic                 w_found;
  logic [IDX_W-1:0]     w_sel_idx;
  rect_t                w_req_rect;
  logic                 w_last;
  logic [NUM_REQ-1:0]   w_grant_nxt;
  logic [NUM_REQ-1:0]   w_done_nxt;
  logic                 w_clear_done_nxt;
  logic                 w_busy_nxt;
  int                   w_idx;

  // A clear pulse seen while busy is remembered until the next IDLE.
  assign w_clear = i_clear_req | r_clear_pend;
  assign w_any   = |i_req;

  // Round-robin pick: first set request searching upward from r_rr_ptr.
  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        w_found   = 1'b1;
        w_sel_idx = IDX_W'(w_idx);
      end
    end
  end

  always_comb begin
    w_req_rect.x      = i_req_x[int'(w_sel_idx)*X_W +: X_W];
    w_req_rect.y      = i_req_y[int'(w_sel_idx)*Y_W +: Y_W];
    w_req_rect.w      = X_W'(i_req_w[int'(w_sel_idx)*DIM_W +: DIM_W]) + X_W'(1);
    w_req_rect.h      = Y_W'(i_req_h[int'(w_sel_idx)*DIM_W +: DIM_W]) + Y_W'(1);
    w_req_rect.colour = i_req_colour[int'(w_sel_idx)*COLOUR_W +: COLOUR_W];
  end

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_clear || w_any) w_state_nxt = ST_LOAD;
      ST_LOAD:   w_state_nxt = ST_DRAW;
      ST_DRAW:   if (w_last) w_state_nxt = ST_FINISH;
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic (values registered below so every port is a flop)
  always_comb begin
    w_grant_nxt      = '0;
    w_done_nxt       = '0;
    w_clear_done_nxt = 1'b0;
    if (r_state == ST_IDLE && !w_clear && w_any) w_grant_nxt[w_sel_idx] = 1'b1;
    if (r_state == ST_DRAW && w_last) begin
      if (r_job_clear) w_clear_done_nxt = 1'b1;
      else             w_done_nxt[r_job_idx] = 1'b1;
    end
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_grant      <= '0;
      r_done       <= '0;
      r_clear_done <= 1'b0;
      r_busy       <= 1'b0;
      r_rr_ptr     <= '0;
      r_job        <= '0;
      r_job_clear  <= 1'b0;
      r_job_idx    <= '0;
      r_clear_pend <= 1'b0;
    end else begin
      r_grant      <= w_grant_nxt;
      r_done       <= w_done_nxt;
      r_clear_done <= w_clear_done_nxt;
      r_busy       <= w_busy_nxt;
      if (r_state == ST_IDLE) begin
        r_clear_pend <= 1'b0;
        if (w_clear) begin
          r_job       <= clear_rect();
          r_job_clear <= 1'b1;
        end else if (w_any) begin
          r_job       <= w_req_rect;
          r_job_clear <= 1'b0;
          r_job_idx   <= w_sel_idx;
        end
      end else begin
        r_clear_pend <= r_clear_pend | i_clear_req;
      end
      if (r_state == ST_FINISH && !r_job_clear)
        r_rr_ptr <= (r_job_idx == IDX_W'(NUM_REQ-1)) ? '0 : r_job_idx + IDX_W'(1);
    end
  end

  rect_rasterizer u_raster (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_start       (r_state == ST_LOAD),
    .i_rect        (r_job),
    .o_plot        (o_plot),
    .o_plot_x      (o_plot_x),
    .o_plot_y      (o_plot_y),
    .o_plot_colour (o_plot_colour),
    .o_last        (w_last)
  );

  assign o_grant      = r_grant;
  assign o_done       = r_done;
  assign o_clear_done = r_clear_done;
  assign o_busy       = r_busy;

endmodule
